// File: rtl/mem_arbiter.sv
// Main-memory arbiter: I-cache fills, D-cache fills and D-cache write-through stores.
// Define ARB_ROUND_ROBIN_EN to alternate the tie winner; default build is fixed D-cache priority.
module mem_arbiter #(
  parameter int WORDS_PER_BLOCK = 8,
  parameter int ADDR_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              icache_req,
  input  logic [ADDR_W-1:0] icache_addr,
  output logic              icache_grant,
  output logic              icache_data_valid,
  input  logic              dcache_req,
  input  logic              dcache_wr,
  input  logic [ADDR_W-1:0] dcache_addr,
  input  logic [ADDR_W-1:0] dcache_wdata,
  output logic              dcache_grant,
  output logic              dcache_data_valid,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ADDR_W-1:0] mem_wdata,
  input  logic              mem_data_valid
);

  localparam int CW = $clog2(WORDS_PER_BLOCK);
  localparam logic [CW:0]   ISSUE_ONE = 1;
  localparam logic [CW-1:0] RX_ONE    = 1;
  localparam logic [CW-1:0] RX_LAST   = {CW{1'b1}};

  typedef enum logic [1:0] {IDLE, FILL_I, FILL_D, WRITE_D} state_t;

  state_t               state_q, state_d;
  logic [CW:0]          issue_cnt_q, issue_cnt_d;
  logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
  logic [ADDR_W-CW-1:0] base_q, base_d;
  logic                 d_wins;
  logic                 unused_addr_bits;

  assign unused_addr_bits = ^icache_addr[CW-1:0];

`ifdef ARB_ROUND_ROBIN_EN
  // last_owner_q: 0 = I-cache, 1 = D-cache
  logic last_owner_q, last_owner_d;
  assign d_wins = !icache_req || !last_owner_q;
`else
  assign d_wins = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      issue_cnt_q <= '0;
      rx_cnt_q    <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_owner_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      rx_cnt_q    <= rx_cnt_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_owner_q <= last_owner_d;
`endif
    end
  end

  // Block base address is datapath only; it is always reloaded before use.
  always_ff @(posedge clk) begin
    base_q <= base_d;
  end

  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    rx_cnt_d    = rx_cnt_q;
    base_d      = base_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_owner_d = last_owner_q;
`endif
    case (state_q)
      IDLE: begin
        issue_cnt_d = '0;
        rx_cnt_d    = '0;
        if (dcache_req && d_wins) begin
          state_d = dcache_wr ? WRITE_D : FILL_D;
          base_d  = dcache_addr[ADDR_W-1:CW];
`ifdef ARB_ROUND_ROBIN_EN
          last_owner_d = 1'b1;
`endif
        end else if (icache_req) begin
          state_d = FILL_I;
          base_d  = icache_addr[ADDR_W-1:CW];
`ifdef ARB_ROUND_ROBIN_EN
          last_owner_d = 1'b0;
`endif
        end
      end
      FILL_I, FILL_D: begin
        // The MSB of issue_cnt marks "all words issued" and freezes the count.
        if (!issue_cnt_q[CW]) issue_cnt_d = issue_cnt_q + ISSUE_ONE;
        if (mem_data_valid) begin
          if (rx_cnt_q == RX_LAST) begin
            state_d     = IDLE;
            issue_cnt_d = '0;
            rx_cnt_d    = '0;
          end else begin
            rx_cnt_d = rx_cnt_q + RX_ONE;
          end
        end
      end
      WRITE_D: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    icache_grant      = 1'b0;
    dcache_grant      = 1'b0;
    icache_data_valid = 1'b0;
    dcache_data_valid = 1'b0;
    mem_en            = 1'b0;
    mem_wr            = 1'b0;
    mem_addr          = '0;
    mem_wdata         = '0;
    case (state_q)
      FILL_I: begin
        icache_grant      = 1'b1;
        icache_data_valid = mem_data_valid;
        mem_en            = !issue_cnt_q[CW];
        if (!issue_cnt_q[CW]) mem_addr = {base_q, issue_cnt_q[CW-1:0]};
      end
      FILL_D: begin
        dcache_grant      = 1'b1;
        dcache_data_valid = mem_data_valid;
        mem_en            = !issue_cnt_q[CW];
        if (!issue_cnt_q[CW]) mem_addr = {base_q, issue_cnt_q[CW-1:0]};
      end
      WRITE_D: begin
        dcache_grant = 1'b1;
        mem_en       = 1'b1;
        mem_wr       = 1'b1;
        mem_addr     = dcache_addr;
        mem_wdata    = dcache_wdata;
      end
      default: ;
    endcase
  end

`ifndef SYNTHESIS
  a_one_grant: assert property (@(posedge clk) disable iff (!rst) !(icache_grant && dcache_grant));
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: cache/memory agents driven against a transaction-level model.
// Define ARB_ROUND_ROBIN_EN here as for the design to select the alternating tie rule.
module tb_mem_arbiter;
  localparam int W     = 8;
  localparam int LAT   = 3;
  localparam int NRAND = 3000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        icache_req = 1'b0;
  logic [15:0] icache_addr = 16'h0;
  logic        icache_grant, icache_data_valid;
  logic        dcache_req = 1'b0;
  logic        dcache_wr = 1'b0;
  logic [15:0] dcache_addr = 16'h0;
  logic [15:0] dcache_wdata = 16'h0;
  logic        dcache_grant, dcache_data_valid;
  logic        mem_en, mem_wr;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_data_valid = 1'b0;

  mem_arbiter #(.WORDS_PER_BLOCK(W), .ADDR_W(16)) dut (
    .clk(clk), .rst(rst),
    .icache_req(icache_req), .icache_addr(icache_addr),
    .icache_grant(icache_grant), .icache_data_valid(icache_data_valid),
    .dcache_req(dcache_req), .dcache_wr(dcache_wr),
    .dcache_addr(dcache_addr), .dcache_wdata(dcache_wdata),
    .dcache_grant(dcache_grant), .dcache_data_valid(dcache_data_valid),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_data_valid(mem_data_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model: owner 0 = none, 1 = I fill, 2 = D fill, 3 = D write; last 1 = I, 2 = D
  int m_owner = 0, m_issued = 0, m_ret = 0, m_last = 1, m_base = 0;
  logic e_ig, e_dg, e_en, e_wr, e_idv, e_ddv;
  logic [15:0] e_addr, e_wd;

  int i_st = 0, i_rx = 0, i_drop = 99;
  int d_st = 0, d_rx = 0;
  bit d_wdone = 1'b0;
  bit di_go = 1'b0, dd_go = 1'b0;
  logic [15:0] di_addr = 16'h0, dd_addr = 16'h0, dd_wdata = 16'h0;
  int di_drop = 99;
  logic dd_wr = 1'b0;
  bit want_reset = 1'b0, force_stray = 1'b0;
  int quiet = 0;
  int obs_i = 0, obs_d = 0, obs_wr = 0;
  int retq[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_zero(input string pfx);
    check_eq({pfx, "_icache_grant"}, icache_grant, 0);
    check_eq({pfx, "_dcache_grant"}, dcache_grant, 0);
    check_eq({pfx, "_icache_dv"}, icache_data_valid, 0);
    check_eq({pfx, "_dcache_dv"}, dcache_data_valid, 0);
    check_eq({pfx, "_mem_en"}, mem_en, 0);
    check_eq({pfx, "_mem_wr"}, mem_wr, 0);
    check_eq({pfx, "_mem_addr"}, mem_addr, 0);
    check_eq({pfx, "_mem_wdata"}, mem_wdata, 0);
  endtask

  function automatic bit d_has_priority();
`ifdef ARB_ROUND_ROBIN_EN
    return !icache_req || (m_last == 1);
`else
    return 1'b1;
`endif
  endfunction

  task automatic drive_agents(input bit auto_stim);
    if (i_st != 0 && i_rx == W) begin
      i_st = 0; icache_req = 1'b0;
    end else if (i_st == 1 && i_rx >= i_drop) begin
      i_st = 2; icache_req = 1'b0;
    end
    if (i_st == 0 && quiet == 0 && (di_go || (auto_stim && $urandom_range(5) == 0))) begin
      i_st = 1; i_rx = 0; icache_req = 1'b1;
      icache_addr = di_go ? di_addr : 16'($urandom);
      i_drop = di_go ? di_drop : (($urandom_range(3) == 0) ? int'($urandom_range(7, 1)) : 99);
      di_go = 1'b0;
    end else if (m_owner == 1 && $urandom_range(3) == 0) begin
      icache_addr = 16'($urandom);
    end

    if (d_st == 1 && (dcache_wr ? d_wdone : (d_rx == W))) begin
      d_st = 0; dcache_req = 1'b0;
    end
    if (d_st == 0 && quiet == 0 && (dd_go || (auto_stim && $urandom_range(7) == 0))) begin
      d_st = 1; d_rx = 0; d_wdone = 1'b0; dcache_req = 1'b1;
      dcache_wr    = dd_go ? dd_wr : 1'($urandom_range(1));
      dcache_addr  = dd_go ? dd_addr : 16'($urandom);
      dcache_wdata = dd_go ? dd_wdata : 16'($urandom);
      dd_go = 1'b0;
    end else if (m_owner == 2 && $urandom_range(3) == 0) begin
      dcache_addr = 16'($urandom);
    end
  endtask

  task automatic drive_mem();
    int dummy;
    mem_data_valid = 1'b0;
    if (retq.size() > 0 && retq[0] == cyc) begin
      mem_data_valid = 1'b1;
      dummy = retq.pop_front();
    end else if ((m_owner == 0 || m_owner == 3) && (force_stray || $urandom_range(11) == 0)) begin
      mem_data_valid = 1'b1;
    end
  endtask

  task automatic check_outputs();
    e_ig   = (m_owner == 1);
    e_dg   = (m_owner >= 2);
    e_en   = ((m_owner == 1 || m_owner == 2) && m_issued < W) || (m_owner == 3);
    e_wr   = (m_owner == 3);
    e_addr = (m_owner == 3) ? dcache_addr : 16'(m_base * W + m_issued);
    e_wd   = (m_owner == 3) ? dcache_wdata : 16'h0;
    e_idv  = (m_owner == 1) && mem_data_valid;
    e_ddv  = (m_owner == 2) && mem_data_valid;
    check_eq("icache_grant", icache_grant, e_ig);
    check_eq("dcache_grant", dcache_grant, e_dg);
    check_eq("mem_en", mem_en, e_en);
    check_eq("mem_wr", mem_wr, e_wr);
    check_eq("mem_wdata", mem_wdata, e_wd);
    check_eq("icache_data_valid", icache_data_valid, e_idv);
    check_eq("dcache_data_valid", dcache_data_valid, e_ddv);
    if (e_en) check_eq("mem_addr", mem_addr, e_addr);
    obs_i  += int'(icache_data_valid === 1'b1);
    obs_d  += int'(dcache_data_valid === 1'b1);
    obs_wr += int'(mem_en === 1'b1 && mem_wr === 1'b1);
    i_rx   += int'(e_idv);
    d_rx   += int'(e_ddv);
    if (m_owner == 3) d_wdone = 1'b1;
  endtask

  task automatic model_advance();
    case (m_owner)
      0: begin
        m_issued = 0;
        m_ret    = 0;
        if (dcache_req && d_has_priority()) begin
          m_owner = dcache_wr ? 3 : 2;
          m_base  = int'(dcache_addr) / W;
          m_last  = 2;
        end else if (icache_req) begin
          m_owner = 1;
          m_base  = int'(icache_addr) / W;
          m_last  = 1;
        end
      end
      1, 2: begin
        if (m_issued < W) m_issued++;
        if (mem_data_valid) begin
          m_ret++;
          if (m_ret == W) m_owner = 0;
        end
      end
      default: m_owner = 0;
    endcase
  endtask

  task automatic apply_reset();
    #1 rst = 1'b0;
    #1;
    check_zero("async_rst");
    m_owner = 0; m_issued = 0; m_ret = 0; m_last = 1;
    i_st = 0; d_st = 0;
    icache_req = 1'b0; dcache_req = 1'b0;
    quiet = LAT + 2;
    want_reset = 1'b0;
  endtask

  task automatic cycle_step(input bit auto_stim);
    bit do_rst;
    @(negedge clk);
    rst = 1'b1;
    drive_agents(auto_stim);
    drive_mem();
    #1;
    check_outputs();
    do_rst = (m_owner == 1 || m_owner == 2) && m_issued >= 4 &&
             (want_reset || (auto_stim && $urandom_range(63) == 0));
    if (e_en && !e_wr && !do_rst) retq.push_back(cyc + LAT);
    if (do_rst) apply_reset();
    else model_advance();
    if (quiet > 0) quiet--;
    cyc++;
  endtask

  task automatic run(input int n, input bit auto_stim);
    for (int k = 0; k < n; k++) cycle_step(auto_stim);
  endtask

  initial begin
    #12;
    check_zero("reset");

    di_go = 1'b1; di_addr = 16'h1234; di_drop = 99;
    run(20, 1'b0);
    check_eq("ifill_words", obs_i, 8);

    dd_go = 1'b1; dd_wr = 1'b1; dd_addr = 16'h00A2; dd_wdata = 16'hBEEF;
    run(5, 1'b0);
    check_eq("dwrite_count", obs_wr, 1);

    dd_go = 1'b1; dd_wr = 1'b0; dd_addr = 16'h4440;
    di_go = 1'b1; di_addr = 16'h7778; di_drop = 99;
    run(40, 1'b0);
    check_eq("tie_iwords", obs_i, 16);
    check_eq("tie_dwords", obs_d, 8);

    di_go = 1'b1; di_addr = 16'h0100; di_drop = 3;
    run(20, 1'b0);
    check_eq("drop_iwords", obs_i, 24);

    di_go = 1'b1; di_addr = 16'h2000; di_drop = 99; want_reset = 1'b1;
    run(20, 1'b0);
    check_eq("reset_taken", want_reset, 0);

    di_go = 1'b1; di_addr = 16'h3000; di_drop = 99;
    run(20, 1'b0);

    force_stray = 1'b1;
    run(3, 1'b0);
    force_stray = 1'b0;
    check_eq("stray_dwords", obs_d, 8);

    run(NRAND, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port main memory between the I-cache and D-cache fill FSMs, plus D-cache write-through stores.
- Grants one requester at a time and sequences a full 8-word block fill as 8 pipelined reads.
- Counts the returned words and steers each data-valid strobe to the owning cache.
- Sits between both cache instances and the memory model; the caches stay stalled while not granted.

Parameters:
- WORDS_PER_BLOCK, 8: words per fill. Must be a power of 2; sets counter width CW = log2(WORDS_PER_BLOCK).
- ADDR_W, 16: address and data width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- icache_req  in  1  I-cache miss fill request, held until done.
- icache_addr  in  16  I-cache miss address. Only [15:3] is used.
- icache_grant  out  1  I-cache owns the memory.
- icache_data_valid  out  1  returned word is for the I-cache.
- dcache_req  in  1  D-cache request (fill or write).
- dcache_wr  in  1  1 = single-word write-through, 0 = block fill.
- dcache_addr  in  16  D-cache address: full word address for writes, [15:3] for fills.
- dcache_wdata  in  16  store data.
- dcache_grant  out  1  D-cache owns the memory.
- dcache_data_valid  out  1  returned word is for the D-cache.
- mem_en  out  1  memory enable.
- mem_wr  out  1  memory write.
- mem_addr  out  16  memory address.
- mem_wdata  out  16  memory write data.
- mem_data_valid  in  1  memory read data valid. Fixed-latency pipelined memory, one word per cycle.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; issue_cnt=0; rx_cnt=0; last_owner=I. All outputs are 0.
- States:
  - IDLE: sample requests. The grant is registered, so it asserts the cycle after a request is seen.
    - dcache_req & dcache_wr -> WRITE_D.
    - dcache_req & ~dcache_wr -> FILL_D.
    - Otherwise icache_req -> FILL_I.
    - Tie: D-cache wins (fixed priority).
  - FILL_I / FILL_D:
    - The matching grant is held high for the whole state.
    - Issue phase: mem_en=1, mem_wr=0, mem_addr={owner_addr[15:3], issue_cnt} for WORDS_PER_BLOCK consecutive cycles. issue_cnt increments 0..7, then saturates and mem_en drops.
    - Return phase: each mem_data_valid pulses the owner's *_data_valid combinationally in the same cycle and increments rx_cnt.
    - When mem_data_valid arrives with rx_cnt==7, go to IDLE next cycle. Grant drops; both counters clear.
    - Issue and return overlap; the returned-word count is the only completion criterion.
  - WRITE_D: one cycle with mem_en=1, mem_wr=1, mem_addr=dcache_addr, mem_wdata=dcache_wdata, dcache_grant=1. Then IDLE.
- Owner address is latched at grant. Changes on *_addr during a fill are ignored.
- A fill is not abortable. If the requester drops req mid-fill, all 8 words are still issued and counted, with data_valid pulses still delivered.
- mem_data_valid in IDLE or WRITE_D (stray or left over from before a reset) is ignored: no data_valid pulse, no counter change.
- Back-to-back: after a fill ends, IDLE takes ≥1 cycle, so at most one grant is high in any cycle. Both grants high is illegal; assert it in simulation.
- mem_wdata = 0 and mem_wr = 0 whenever not in WRITE_D.
- Reset mid-fill: return to IDLE immediately; the late memory returns are dropped per the stray-valid rule.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: on a simultaneous request, grant the cache that was not last_owner. last_owner updates at every grant.
- Undefined: fixed D-cache priority; last_owner is unused and not synthesized.

Test Plan:
- I-fill alone: icache_req=1, addr=0x1234 -> icache_grant next cycle; mem_addr 0x1230..0x1237 on 8 consecutive cycles; exactly 8 icache_data_valid pulses; grant drops the cycle after the 8th.
- D write: dcache_req=1, wr=1, addr=0x00A2, wdata=0xBEEF -> one cycle with mem_en=1, mem_wr=1, mem_addr=0x00A2, mem_wdata=0xBEEF; then IDLE.
- Tie: both fill reqs in the same cycle -> D fill served first (0 I pulses during it), then I fill; with ARB_ROUND_ROBIN_EN and last_owner=D, I is served first.
- Req drop: icache_req deasserted after 3 words -> fill still completes 8 words; grant stays high until the 8th valid.
- Reset mid-fill: rst low after 4 issues -> all outputs 0 asynchronously; the remaining mem_data_valid pulses produce no data_valid; a new request is served normally.
- Stray valid in IDLE: mem_data_valid=1 with no owner -> both data_valids stay 0; rx_cnt stays 0.
